pipelined_approx_adder: RTL and testbench
=========================================

// Module: pipelined_approx_adder
// PURPOSE
//  Parametrised, pipelined N-bit ripple adder; carry crosses one SEG-bit segment per stage.
//  Runtime-selectable lower-part-OR approximation of the APPROX_BITS LSBs (exact or approximate per transaction).
//  Valid/ready streaming interface; next-generation datapath adder for the approximate-computing arithmetic units.
// PARAMETERS
//  WIDTH        16  operand/sum width; WIDTH % SEG == 0 required (elaboration error otherwise)
//  SEG           4  bits per pipeline segment; latency = WIDTH/SEG cycles
//  APPROX_BITS   4  LSBs approximated when approx_en=1; 0..WIDTH; 0 => always exact
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block accepts operands this cycle
//  in1        in   WIDTH  operand A
//  in2        in   WIDTH  operand B
//  cin        in   1      carry-in (ignored when approx_en=1 and APPROX_BITS>0)
//  approx_en  in   1      1 = approximate mode for this transaction
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry-out of MSB
// BEHAVIOUR
//  - Reset (async assert, sync deassert by environment): all stage valid bits, out_valid, sum, cout -> 0; in_ready -> 1 once reset is released.
//  - Pipeline of S=WIDTH/SEG stages; stage k adds segment k using carry from stage k-1; unprocessed operand
//    segments skewed forward, finished sum segments deskewed so sum/cout emerge aligned.
//  - Global advance: adv = !out_valid || out_ready; in_ready = adv; transfer on in_valid && in_ready.
//  - Latency: accepted at edge t -> out_valid high after edge t+S; throughput 1/cycle while out_ready=1.
//  - Stall: out_valid && !out_ready freezes all stages; sum/cout/out_valid held stable; in_ready=0.
//  - Bubbles propagate as valid=0 stages; no reordering, no drops, no duplicates.
//  - approx_en captured with operands and carried per transaction down the pipe; mode switching is free back-to-back.
//  - Approximate mode (APPROX_BITS=L>0): sum[L-1:0] = in1[L-1:0] | in2[L-1:0];
//    carry into bit L = in1[L-1] & in2[L-1]; cin ignored; bits >= L added exactly.
//  - Exact mode: {cout,sum} = in1 + in2 + cin, modulo 2^(WIDTH+1).
//  - Wrap-around: 0xFFFF + 0x0001 -> sum 0x0000, cout 1 (no saturation).
//  - Reset mid-operation: all in-flight transactions discarded; no output produced for them.
// CONFIGURATION
//  Macro APPROX_ADDER_ERR_MON_EN:
//   defined: adds parallel exact adder (same pipeline alignment) and outputs
//     err_cnt  out 32     count of delivered approx results != exact result (saturates at all-ones)
//     err_mag  out WIDTH+8  sum of |exact - approx| over delivered results (saturating)
//     err_clr  in  1      synchronous clear of both counters (priority over increment same cycle)
//    counters update only on out_valid && out_ready; reset to 0.
//   undefined: ports and logic absent; core behaviour identical.
// STRUCTURE
//  - Package approx_adder_pkg: mode typedef (MODE_EXACT=0, MODE_APPROX=1), localparam function for stage count,
//    err_cnt width constant.
//  - Sub-module adder_segment: SEG-bit combinational ripple (chain of one_bit_vedic_adder cells) with
//    per-bit approximation mask input; instantiated S times via generate.
//  - Top holds skew/deskew registers, valid chain, handshake, optional monitor.
// TESTING (WIDTH=16, SEG=4, APPROX_BITS=4)
//  1 Exact: in1=0x00FF, in2=0x0001, cin=0 -> after 4 cycles sum=0x0100, cout=0.
//  2 Approx: in1=0x00FF, in2=0x0001 -> sum=0x00FF, cout=0; with monitor err_cnt=1, err_mag=1.
//  3 Approx carry: in1=0x0008, in2=0x0008, cin=1 -> sum=0x0018 (exact 0x0011); err_mag += 7.
//  4 Wrap: exact 0xFFFF+0x0001, cin=0 -> sum=0x0000, cout=1; 0xFFFF+0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
//  5 Backpressure: stream 8 back-to-back mixed-mode ops, out_ready low 3 cycles mid-stream -> in_ready low
//    while stalled, outputs held, all 8 results in order and correct, throughput 1/cycle otherwise.
//  6 Reset mid-flight: assert rst_n=0 with 3 ops in pipe -> out_valid=0 immediately, no stale results after release.

Source files
------------

// File: rtl/approx_adder_pkg.sv
// Shared types and constants for the pipelined approximate adder.
package approx_adder_pkg;

  typedef enum logic {
    MODE_EXACT  = 1'b0,
    MODE_APPROX = 1'b1
  } mode_e;

  localparam int ERR_CNT_W = 32;

  function automatic int num_stages(input int width, input int seg);
    return width / seg;
  endfunction

endpackage

// File: rtl/adder_segment.sv
// SEG-bit combinational ripple segment built from one-bit cells with a per-bit approximation mask.
module adder_segment #(
  parameter int SEG = 4
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           ci_i,
  input  logic [SEG-1:0] mask_i,
  output logic [SEG-1:0] s_o,
  output logic           co_o
);

  logic [SEG:0] c;
  assign c[0] = ci_i;

  for (genvar i = 0; i < SEG; i++) begin : g_bit
    one_bit_vedic_adder u_bit (
      .a_i      (a_i[i]),
      .b_i      (b_i[i]),
      .ci_i     (c[i]),
      .approx_i (mask_i[i]),
      .s_o      (s_o[i]),
      .co_o     (c[i+1])
    );
  end

  assign co_o = c[SEG];

endmodule

// File: rtl/one_bit_vedic_adder.sv
// One-bit adder cell; when approx_i is set it emits a|b and generates a&b, ignoring carry-in.
module one_bit_vedic_adder (
  input  logic a_i,
  input  logic b_i,
  input  logic ci_i,
  input  logic approx_i,
  output logic s_o,
  output logic co_o
);

  logic p;
  assign p    = a_i ^ b_i;
  assign s_o  = approx_i ? (a_i | b_i) : (p ^ ci_i);
  assign co_o = approx_i ? (a_i & b_i) : ((a_i & b_i) | (p & ci_i));

endmodule

// File: rtl/pipelined_approx_adder.sv
// Pipelined segmented adder with per-transaction lower-part-OR approximation and valid/ready handshake.
// Define APPROX_ADDER_ERR_MON_EN to add a parallel exact pipe plus error count/magnitude monitors.
module pipelined_approx_adder
  import approx_adder_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int SEG         = 4,
  parameter int APPROX_BITS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             approx_en,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef APPROX_ADDER_ERR_MON_EN
  input  logic                 err_clr,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [WIDTH+7:0]     err_mag,
`endif
  output logic             cout
);

  localparam int S = num_stages(WIDTH, SEG);
  localparam logic [WIDTH-1:0] ONES  = '1;
  localparam logic [WIDTH-1:0] AMASK = ONES >> (WIDTH - APPROX_BITS);

  if (WIDTH % SEG != 0) begin : g_bad_seg
    $error("WIDTH must be a multiple of SEG");
  end
  if (APPROX_BITS < 0 || APPROX_BITS > WIDTH) begin : g_bad_approx
    $error("APPROX_BITS must lie in 0..WIDTH");
  end

  // acc_q[k] holds the unconsumed operand-A segments in its low bits while finished
  // sum segments shift in from the top; after S stages it is exactly the aligned sum.
  logic [S:0]       vld_pipe_q;
  logic [S:0]       cry_q;
  mode_e            mode_q [S];
  logic [WIDTH-1:0] acc_q  [S+1];
  logic [WIDTH-1:0] opb_q  [S];
  logic [SEG-1:0]   seg_s  [S];
  logic [S-1:0]     seg_co;
  logic             adv;

  assign adv       = !vld_pipe_q[S] || out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_pipe_q[S];
  assign sum       = acc_q[S];
  assign cout      = cry_q[S];

  for (genvar k = 0; k < S; k++) begin : g_stage
    logic [SEG-1:0] mask;
    assign mask = (mode_q[k] == MODE_APPROX) ? AMASK[k*SEG +: SEG] : '0;
    adder_segment #(.SEG(SEG)) u_seg (
      .a_i    (acc_q[k][SEG-1:0]),
      .b_i    (opb_q[k][SEG-1:0]),
      .ci_i   (cry_q[k]),
      .mask_i (mask),
      .s_o    (seg_s[k]),
      .co_o   (seg_co[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      cry_q      <= '0;
      for (int k = 0; k < S; k++) begin
        mode_q[k] <= MODE_EXACT;
        opb_q[k]  <= '0;
      end
      for (int k = 0; k <= S; k++) acc_q[k] <= '0;
    end else if (adv) begin
      vld_pipe_q <= {vld_pipe_q[S-1:0], in_valid};
      acc_q[0]   <= in1;
      opb_q[0]   <= in2;
      cry_q[0]   <= cin;
      mode_q[0]  <= approx_en ? MODE_APPROX : MODE_EXACT;
      for (int k = 0; k < S; k++) begin
        acc_q[k+1] <= (acc_q[k] >> SEG) | (WIDTH'(seg_s[k]) << (WIDTH - SEG));
        cry_q[k+1] <= seg_co[k];
      end
      for (int k = 1; k < S; k++) begin
        opb_q[k]  <= opb_q[k-1] >> SEG;
        mode_q[k] <= mode_q[k-1];
      end
    end
  end

`ifdef APPROX_ADDER_ERR_MON_EN
  // Shadow exact pipe shares operand B with the main pipe and stays in lockstep with it.
  logic [WIDTH-1:0]     eacc_q [S+1];
  logic [S:0]           ecry_q;
  logic [SEG-1:0]       eseg_s [S];
  logic [S-1:0]         eseg_co;
  logic [WIDTH:0]       ares, eres, diff;
  logic [WIDTH+8:0]     mag_sum;
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [WIDTH+7:0]     err_mag_q, err_mag_d;

  for (genvar k = 0; k < S; k++) begin : g_estage
    adder_segment #(.SEG(SEG)) u_eseg (
      .a_i    (eacc_q[k][SEG-1:0]),
      .b_i    (opb_q[k][SEG-1:0]),
      .ci_i   (ecry_q[k]),
      .mask_i ('0),
      .s_o    (eseg_s[k]),
      .co_o   (eseg_co[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ecry_q <= '0;
      for (int k = 0; k <= S; k++) eacc_q[k] <= '0;
    end else if (adv) begin
      eacc_q[0] <= in1;
      ecry_q[0] <= cin;
      for (int k = 0; k < S; k++) begin
        eacc_q[k+1] <= (eacc_q[k] >> SEG) | (WIDTH'(eseg_s[k]) << (WIDTH - SEG));
        ecry_q[k+1] <= eseg_co[k];
      end
    end
  end

  assign ares    = {cry_q[S], acc_q[S]};
  assign eres    = {ecry_q[S], eacc_q[S]};
  assign diff    = (eres >= ares) ? (eres - ares) : (ares - eres);
  assign mag_sum = {1'b0, err_mag_q} + (WIDTH+9)'(diff);

  always_comb begin
    err_cnt_d = err_cnt_q;
    err_mag_d = err_mag_q;
    if (err_clr) begin
      err_cnt_d = '0;
      err_mag_d = '0;
    end else if (out_valid && out_ready) begin
      if (ares != eres && !(&err_cnt_q)) err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
      err_mag_d = mag_sum[WIDTH+8] ? '1 : mag_sum[WIDTH+7:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= '0;
      err_mag_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_mag_q <= err_mag_d;
    end
  end

  assign err_cnt = err_cnt_q;
  assign err_mag = err_mag_q;
`endif

endmodule

// File: tb/tb_pipelined_approx_adder.sv
// Directed, table-driven bench for pipelined_approx_adder (WIDTH=16, SEG=4, APPROX_BITS=4).
module tb_pipelined_approx_adder;

  localparam int W  = 16;
  localparam int NV = 12;

  logic         clk, rst_n, in_valid, in_ready, cin, approx_en, out_valid, out_ready, cout;
  logic [W-1:0] in1, in2, sum;
`ifdef APPROX_ADDER_ERR_MON_EN
  logic         err_clr;
  logic [31:0]  err_cnt;
  logic [W+7:0] err_mag;
`endif

  pipelined_approx_adder #(.WIDTH(W), .SEG(4), .APPROX_BITS(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef APPROX_ADDER_ERR_MON_EN
    .err_clr   (err_clr),
    .err_cnt   (err_cnt),
    .err_mag   (err_mag),
`endif
    .cout      (cout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         ap;
    logic [W-1:0] s;
    logic         co;
  } vec_t;

  vec_t tv [NV];
  int   checks   = 0;
  int   failures = 0;
  int   rx_cnt;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input int i);
    in1       = tv[i].a;
    in2       = tv[i].b;
    cin       = tv[i].ci;
    approx_en = tv[i].ap;
    in_valid  = 1'b1;
  endtask

  // Streams n table vectors starting at 'first'; optional 3-cycle out_ready drop after 2 results.
  task automatic run_stream(input int first, input int n, input bit bp);
    rx_cnt = 0;
    fork
      begin : drv
        for (int i = 0; i < n; i++) begin
          int g = 0;
          @(negedge clk);
          drive(first + i);
          while (!in_ready && g < 100) begin
            @(negedge clk);
            g++;
          end
        end
        @(negedge clk);
        in_valid = 1'b0;
      end
      begin : mon
        int cyc = 0;
        int last = 0;
        bit stalled = 0;
        logic [W-1:0] hs;
        logic hc;
        while (rx_cnt < n && cyc < 300) begin
          @(negedge clk);
          cyc++;
          if (stalled) begin
            chk("stall_hold_vld", out_valid, 1);
            chk("stall_hold_sum", sum, hs);
            chk("stall_hold_cout", cout, hc);
          end
          stalled = 0;
          if (out_valid) begin
            if (out_ready) begin
              chk($sformatf("sum[%0d]", first + rx_cnt), sum, tv[first + rx_cnt].s);
              chk($sformatf("cout[%0d]", first + rx_cnt), cout, tv[first + rx_cnt].co);
              if (!bp && rx_cnt > 0) chk("throughput_gap", cyc - last, 1);
              last = cyc;
              rx_cnt++;
            end else begin
              chk("stall_in_ready", in_ready, 0);
              stalled = 1;
              hs = sum;
              hc = cout;
            end
          end
        end
        chk("stream_complete", rx_cnt, n);
      end
      begin : rdy
        if (bp) begin
          int g = 0;
          while (rx_cnt < 2 && g < 300) begin
            @(posedge clk);
            #1;
            g++;
          end
          out_ready = 1'b0;
          repeat (3) begin
            @(posedge clk);
            #1;
          end
          out_ready = 1'b1;
        end
      end
    join
  endtask

  initial begin
    //          a         b         ci    ap    sum       cout
    tv[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0};
    tv[1]  = '{16'h00FF, 16'h0001, 1'b0, 1'b1, 16'h00FF, 1'b0};
    tv[2]  = '{16'h0008, 16'h0008, 1'b1, 1'b1, 16'h0018, 1'b0};
    tv[3]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1};
    tv[4]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1};
    tv[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0};
    tv[6]  = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1};
    tv[7]  = '{16'h0005, 16'h000A, 1'b1, 1'b1, 16'h000F, 1'b0};
    tv[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1};
    tv[9]  = '{16'h0000, 16'h0000, 1'b1, 1'b0, 16'h0001, 1'b0};
    tv[10] = '{16'h00A3, 16'h0057, 1'b0, 1'b1, 16'h00F7, 1'b0};
    tv[11] = '{16'h000F, 16'h000F, 1'b1, 1'b1, 16'h001F, 1'b0};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in1 = '0; in2 = '0; cin = 1'b0; approx_en = 1'b0;
`ifdef APPROX_ADDER_ERR_MON_EN
    err_clr = 1'b0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", in_ready, 1);

    // Latency: accepted at edge t, result valid after edge t+4
    @(negedge clk);
    drive(0);
    @(negedge clk);
    in_valid = 1'b0;
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      chk($sformatf("latency_vld_%0d", n), out_valid, (n == 4) ? 1 : 0);
    end
    chk("latency_sum", sum, 16'h0100);
    chk("latency_cout", cout, 0);

`ifdef APPROX_ADDER_ERR_MON_EN
    run_stream(1, 2, 1'b0);
    @(negedge clk);
    chk("err_cnt", err_cnt, 2);
    chk("err_mag", err_mag, 8);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_cnt_clr", err_cnt, 0);
    chk("err_mag_clr", err_mag, 0);
`endif

    // Full table, back-to-back, no backpressure
    run_stream(0, NV, 1'b0);

    // Mixed-mode stream with a 3-cycle output stall mid-stream
    run_stream(0, 8, 1'b1);

    // Reset while three transactions are in flight and the head is stalled
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive(3 + i);
    end
    @(negedge clk);
    in_valid = 1'b0;
    begin
      int g = 0;
      while (!out_valid && g < 20) begin
        @(negedge clk);
        g++;
      end
    end
    chk("midrst_pre_vld", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_sum", sum, 0);
    chk("midrst_cout", cout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    begin
      int stale = 0;
      repeat (10) begin
        @(negedge clk);
        if (out_valid) stale++;
      end
      chk("midrst_no_stale", stale, 0);
    end
    run_stream(5, 1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
